fsm_state_monitor: RTL and testbench
====================================

Name: fsm_state_monitor

Overview:
- Sits directly downstream of the generated one-hot control FSM and consumes its present-state bus every cycle.
- Detects state transitions and measures the dwell time of each state.
- Queues transition records in a small FWFT FIFO, read out over a valid/ready interface.
- Raises sticky flags for illegal encodings, dwell timeouts and FIFO overflow, and a level flag while the FSM is in its terminal trap state.

Parameters:
- CNT_W, 16, width of the dwell counter and evt_dwell.
- TIMEOUT, 1000, dwell count (cycles) at which timeout is raised; must be < 2^CNT_W.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- state_in  in  4  FSM present state, one-hot: init=1000, secondry=0100, blackhole=0010, third=0001.
- clear  in  1  clears the sticky flags.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_from  out  4  head record: state left.
- evt_to  out  4  head record: state entered.
- evt_dwell  out  CNT_W  head record: cycles spent in evt_from (saturated).
- fifo_level  out  clog2(DEPTH)+1  entries held.
- trapped  out  1  registered; 1 while the last sampled state_in == 0010.
- illegal  out  1  sticky: a non-one-hot encoding was sampled.
- timeout  out  1  sticky: a non-blackhole state dwelt for TIMEOUT cycles.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0 at posedge):
  - prev_state <= 1000, dwell_cnt <= 0.
  - FIFO emptied; fifo_level=0, evt_valid=0.
  - evt_from/evt_to/evt_dwell=0; trapped, illegal, timeout and overflow = 0.
  - Reset overrides every other input, including mid-transfer and a full FIFO.
- Sampling: every non-reset posedge compares state_in to prev_state.
  - Equal: dwell_cnt <= dwell_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - Different (transition):
    - Push {prev_state, state_in, dwell_cnt}.
    - prev_state <= state_in.
    - dwell_cnt <= 1 (the transition cycle counts as the new state's first cycle).
- First cycle after reset with state_in=1000 is not a transition; dwell_cnt becomes 1.
- Illegal encoding (popcount(state_in) != 1, including 0000):
  - illegal set next cycle.
  - The value is still compared and recorded like any state.
- Timeout: when dwell_cnt == TIMEOUT-1, state_in == prev_state and prev_state != 0010, set timeout.
  - This asserts timeout on the posedge where dwell_cnt becomes TIMEOUT.
  - Re-entering the state later does not clear it.
- trapped <= (state_in == 0010) each cycle; it is not sticky.
- clear: illegal, timeout and overflow <= 0 at the next posedge.
  - If a set condition occurs in the same cycle, set wins.
  - clear does not touch the FIFO, dwell_cnt or prev_state.
- FIFO, first-word-fall-through:
  - evt_valid = (fifo_level != 0); evt_* present the head combinationally from storage, and 0 when empty.
  - Pop on evt_valid & evt_ready. The head must hold stable while evt_valid=1 and evt_ready=0.
  - Latency: transition sampled at edge N -> evt_valid=1 after edge N when the FIFO was empty.
  - Push with FIFO full and no pop: record dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow, level unchanged.
  - Push and pop in the same cycle while empty: no pop occurs; level becomes 1.
  - Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH; full/empty come from fifo_level.
- All outputs except evt_* are registered.

Test Plan:
- Reset, hold state_in=1000 for 5 cycles -> evt_valid=0, fifo_level=0, no flags; then 0100 -> next cycle evt_valid=1, evt_from=1000, evt_to=0100, evt_dwell=5.
- evt_ready=1, sequence 1000(3 cycles) -> 0100(2) -> 0001(4) -> 0010 -> records {1000,0100,3}, {0100,0001,2}, {0001,0010,4} in order; trapped=1 one cycle after 0010 is sampled; dwell in 0010 past TIMEOUT leaves timeout=0.
- Hold 0100 for TIMEOUT cycles with TIMEOUT=10 -> timeout=1 after the 10th cycle in 0100; pulse clear -> timeout=0 next cycle.
- evt_ready=0, 9 transitions with DEPTH=8 -> fifo_level=8, overflow=1, the 9th record is absent; then push and pop in the same cycle while full -> level stays 8, no new drop.
- state_in=1100 for one cycle between 1000 and 0100 -> illegal=1, records {1000,1100,n} and {1100,0100,1}; clear asserted on the same cycle as a new illegal sample -> illegal stays 1.
- reset=0 asserted with 3 queued records and evt_ready toggling -> next cycle fifo_level=0, evt_valid=0, all flags 0, prev_state=1000.

Source files
------------

// File: rtl/fsm_state_monitor.sv
// fsm_state_monitor
//
// Watches the one-hot present-state bus of the control FSM. On every clock it
// either extends the dwell count of the current state or, on a change, queues
// a {from, to, dwell} record in a small first-word-fall-through FIFO. It also
// keeps sticky flags for illegal encodings, dwell timeouts and dropped records,
// and a level flag while the FSM sits in its blackhole trap state.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-low
//   state_in   FSM present state (init=1000, secondry=0100, blackhole=0010, third=0001)
//   clear      clears illegal/timeout/overflow at the next edge (a new set wins)
//   evt_valid  FIFO head is valid
//   evt_ready  consumer accepts the head
//   evt_from   head record: state left
//   evt_to     head record: state entered
//   evt_dwell  head record: cycles spent in evt_from (saturated)
//   fifo_level entries held
//   trapped    last sampled state was blackhole
//   illegal    sticky: non-one-hot encoding sampled
//   timeout    sticky: a non-blackhole state dwelt for TIMEOUT cycles
//   overflow   sticky: a record was dropped on a full FIFO

module fsm_state_monitor #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000,
   parameter int DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               state_in,
   input  logic                     clear,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [3:0]               evt_from,
   output logic [3:0]               evt_to,
   output logic [CNT_W-1:0]         evt_dwell,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     trapped,
   output logic                     illegal,
   output logic                     timeout,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [3:0]       ST_INIT      = 4'b1000;
   localparam logic [3:0]       ST_BLACKHOLE = 4'b0010;
   localparam logic [CNT_W-1:0] DWELL_MAX    = '1;
   // Terminal-count compare: the flag lands on the edge where dwell_cnt
   // reaches TIMEOUT, so the comparison is made one count earlier.
   localparam logic [CNT_W-1:0] TIMEOUT_TC   = CNT_W'(TIMEOUT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(DEPTH);

   logic [3:0]        prev_state;
   logic [CNT_W-1:0]  dwell_cnt;

   logic [3:0]        mem_from  [DEPTH];
   logic [3:0]        mem_to    [DEPTH];
   logic [CNT_W-1:0]  mem_dwell [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic              transition;
   logic              one_hot;
   logic              fifo_full;
   logic              pop;
   logic              push;
   logic              drop;
   logic              timeout_hit;

   always_comb begin
      transition  = (state_in != prev_state);
      one_hot     = (state_in != 4'd0) && ((state_in & (state_in - 4'd1)) == 4'd0);
      fifo_full   = (fifo_level == LVL_FULL);
      pop         = evt_valid & evt_ready;
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push        = transition & (~fifo_full | pop);
      drop        = transition & fifo_full & ~pop;
      timeout_hit = ~transition & (dwell_cnt == TIMEOUT_TC) & (prev_state != ST_BLACKHOLE);
   end

   always_comb begin
      evt_valid = (fifo_level != '0);
      evt_from  = '0;
      evt_to    = '0;
      evt_dwell = '0;
      if (evt_valid) begin
         evt_from  = mem_from[rd_ptr];
         evt_to    = mem_to[rd_ptr];
         evt_dwell = mem_dwell[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_state <= ST_INIT;
         dwell_cnt  <= '0;
      end else if (transition) begin
         prev_state <= state_in;
         dwell_cnt  <= CNT_W'(1);
      end else if (dwell_cnt != DWELL_MAX) begin
         dwell_cnt  <= dwell_cnt + CNT_W'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem_from[wr_ptr]  <= prev_state;
         mem_to[wr_ptr]    <= state_in;
         mem_dwell[wr_ptr] <= dwell_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         trapped  <= 1'b0;
         illegal  <= 1'b0;
         timeout  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         trapped  <= (state_in == ST_BLACKHOLE);
         illegal  <= ~one_hot     | (illegal  & ~clear);
         timeout  <= timeout_hit  | (timeout  & ~clear);
         overflow <= drop         | (overflow & ~clear);
      end
   end

endmodule

// File: tb/tb_fsm_state_monitor.sv
module tb_fsm_state_monitor;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 10;
   localparam int DEPTH   = 8;
   localparam int DMAX    = (1 << CNT_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [3:0]             st;
   logic                   clr;
   logic                   rdy;
   logic                   evt_valid;
   logic [3:0]             evt_from;
   logic [3:0]             evt_to;
   logic [CNT_W-1:0]       evt_dwell;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   trapped;
   logic                   illegal;
   logic                   timeout;
   logic                   overflow;

   fsm_state_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (rst),
      .state_in   (st),
      .clear      (clr),
      .evt_valid  (evt_valid),
      .evt_ready  (rdy),
      .evt_from   (evt_from),
      .evt_to     (evt_to),
      .evt_dwell  (evt_dwell),
      .fifo_level (fifo_level),
      .trapped    (trapped),
      .illegal    (illegal),
      .timeout    (timeout),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] f;
      logic [3:0] t;
      int         d;
   } rec_t;

   // Reference model: a record queue plus plain counters and flags.
   rec_t       m_q[$];
   logic [3:0] m_prev  = 4'b1000;
   int         m_dwell = 0;
   bit         m_trap  = 0;
   bit         m_ill   = 0;
   bit         m_to    = 0;
   bit         m_ov    = 0;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int ones(input logic [3:0] s);
      int c = 0;
      for (int i = 0; i < 4; i++) c += int'(s[i]);
      return c;
   endfunction

   task automatic model_step();
      rec_t r;
      bit   trans;
      bit   set_ov;
      int   nd;
      if (!rst) begin
         m_q.delete();
         m_prev  = 4'b1000;
         m_dwell = 0;
         m_trap  = 0;
         m_ill   = 0;
         m_to    = 0;
         m_ov    = 0;
         return;
      end
      trans  = (st != m_prev);
      nd     = trans ? 1 : ((m_dwell < DMAX) ? m_dwell + 1 : DMAX);
      set_ov = 0;
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (trans) begin
         r.f = m_prev;
         r.t = st;
         r.d = m_dwell;
         if (m_q.size() < DEPTH) m_q.push_back(r);
         else set_ov = 1;
      end
      m_ill  = (ones(st) != 1) || (m_ill && !clr);
      m_to   = (!trans && m_prev != 4'b0010 && nd == TIMEOUT) || (m_to && !clr);
      m_ov   = set_ov || (m_ov && !clr);
      m_trap = (st == 4'b0010);
      m_prev = st;
      m_dwell = nd;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
         chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
         chk("evt_from", 64'(evt_from), (m_q.size() > 0) ? 64'(m_q[0].f) : 64'd0);
         chk("evt_to", 64'(evt_to), (m_q.size() > 0) ? 64'(m_q[0].t) : 64'd0);
         chk("evt_dwell", 64'(evt_dwell), (m_q.size() > 0) ? 64'(m_q[0].d) : 64'd0);
         chk("trapped", 64'(trapped), 64'(m_trap));
         chk("illegal", 64'(illegal), 64'(m_ill));
         chk("timeout", 64'(timeout), 64'(m_to));
         chk("overflow", 64'(overflow), 64'(m_ov));
      end
   end

   task automatic tick(input logic [3:0] s, input logic r, input logic c, input logic rs);
      st  = s;
      rdy = r;
      clr = c;
      rst = rs;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   rec_t cap[$];

   initial begin
      logic [3:0] legal [4];
      logic [3:0] cur;
      legal[0] = 4'b1000; legal[1] = 4'b0100; legal[2] = 4'b0010; legal[3] = 4'b0001;

      st = 4'b1000; rdy = 0; clr = 0; rst = 0;
      @(negedge clk);
      tick(4'b1000, 0, 0, 0);
      chk_en = 1;

      // Five cycles in init, then the first transition.
      for (int i = 0; i < 5; i++) tick(4'b1000, 0, 0, 1);
      chk("p1 valid", 64'(evt_valid), 64'd0);
      chk("p1 level", 64'(fifo_level), 64'd0);
      chk("p1 flags", 64'({illegal, timeout, overflow, trapped}), 64'd0);
      tick(4'b0100, 0, 0, 1);
      chk("p1 head valid", 64'(evt_valid), 64'd1);
      chk("p1 head from", 64'(evt_from), 64'h8);
      chk("p1 head to", 64'(evt_to), 64'h4);
      chk("p1 head dwell", 64'(evt_dwell), 64'd5);

      // Record sequence into the trap state, which never times out.
      tick(4'b1000, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(4'b1000, 1, 0, 1);
      for (int i = 0; i < 2; i++) begin
         tick(4'b0100, 1, 0, 1);
         if (evt_valid) cap.push_back('{evt_from, evt_to, int'(evt_dwell)});
      end
      for (int i = 0; i < 4; i++) begin
         tick(4'b0001, 1, 0, 1);
         if (evt_valid) cap.push_back('{evt_from, evt_to, int'(evt_dwell)});
      end
      tick(4'b0010, 1, 0, 1);
      if (evt_valid) cap.push_back('{evt_from, evt_to, int'(evt_dwell)});
      chk("p2 trapped", 64'(trapped), 64'd1);
      chk("p2 records", 64'(cap.size()), 64'd3);
      if (cap.size() == 3) begin
         chk("p2 rec0", {52'd0, cap[0].f, cap[0].t, 4'(cap[0].d)}, 64'h843);
         chk("p2 rec1", {52'd0, cap[1].f, cap[1].t, 4'(cap[1].d)}, 64'h412);
         chk("p2 rec2", {52'd0, cap[2].f, cap[2].t, 4'(cap[2].d)}, 64'h124);
      end
      for (int i = 0; i < TIMEOUT + 5; i++) tick(4'b0010, 1, 0, 1);
      chk("p2 trap no timeout", 64'(timeout), 64'd0);
      chk("p2 still trapped", 64'(trapped), 64'd1);

      // Timeout after the TIMEOUT-th cycle in 0100, then clear.
      tick(4'b1000, 0, 0, 0);
      tick(4'b1000, 1, 0, 1);
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick(4'b0100, 1, 0, 1);
         if (i == TIMEOUT - 1) chk("p3 timeout early", 64'(timeout), 64'd0);
      end
      chk("p3 timeout set", 64'(timeout), 64'd1);
      tick(4'b0100, 1, 1, 1);
      chk("p3 timeout clear", 64'(timeout), 64'd0);

      // Overflow with nine transitions, then push+pop while full.
      tick(4'b1000, 0, 0, 0);
      for (int i = 0; i < 9; i++) tick((i % 2 == 0) ? 4'b0100 : 4'b1000, 0, 0, 1);
      chk("p4 level full", 64'(fifo_level), 64'd8);
      chk("p4 overflow", 64'(overflow), 64'd1);
      chk("p4 head", {52'd0, evt_from, evt_to, evt_dwell[3:0]}, 64'h840);
      tick(4'b0100, 0, 1, 1);
      chk("p4 overflow clear", 64'(overflow), 64'd0);
      tick(4'b1000, 1, 0, 1);
      chk("p4 level kept", 64'(fifo_level), 64'd8);
      chk("p4 no drop", 64'(overflow), 64'd0);
      chk("p4 next head", {52'd0, evt_from, evt_to, evt_dwell[3:0]}, 64'h481);

      // Illegal encoding recorded like any state; set beats clear.
      tick(4'b1000, 0, 0, 0);
      tick(4'b1000, 0, 0, 1);
      tick(4'b1000, 0, 0, 1);
      tick(4'b1100, 0, 0, 1);
      chk("p5 illegal", 64'(illegal), 64'd1);
      chk("p5 rec0", {52'd0, evt_from, evt_to, evt_dwell[3:0]}, 64'h8c2);
      tick(4'b0100, 0, 0, 1);
      tick(4'b0100, 1, 0, 1);
      chk("p5 rec1", {52'd0, evt_from, evt_to, evt_dwell[3:0]}, 64'hc41);
      tick(4'b0000, 0, 1, 1);
      chk("p5 set beats clear", 64'(illegal), 64'd1);
      tick(4'b0100, 0, 1, 1);
      chk("p5 illegal clear", 64'(illegal), 64'd0);

      // Reset with records queued and ready toggling.
      tick(4'b1000, 0, 0, 0);
      tick(4'b0100, 0, 0, 1);
      tick(4'b1000, 0, 0, 1);
      tick(4'b0100, 0, 0, 1);
      chk("p6 level 3", 64'(fifo_level), 64'd3);
      tick(4'b0100, 1, 0, 1);
      tick(4'b0100, 1, 0, 0);
      chk("p6 level", 64'(fifo_level), 64'd0);
      chk("p6 valid", 64'(evt_valid), 64'd0);
      chk("p6 flags", 64'({illegal, timeout, overflow, trapped}), 64'd0);
      tick(4'b1000, 0, 0, 1);
      chk("p6 init no event", 64'(evt_valid), 64'd0);
      tick(4'b0100, 0, 0, 1);
      chk("p6 head", {52'd0, evt_from, evt_to, evt_dwell[3:0]}, 64'h841);

      // Random traffic against the model.
      cur = 4'b1000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 25) begin
            if ($urandom_range(9) == 0) cur = 4'($urandom_range(15));
            else cur = legal[$urandom_range(3)];
         end
         tick(cur, 1'($urandom_range(1)), ($urandom_range(19) == 0),
              !($urandom_range(299) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
